// File: rtl/carregador_serial_comparador_pkg.sv
// pacote_comparador: shared state encoding and operand width for the serial loader
package pacote_comparador;
    localparam int OP_W = 3;
    typedef enum logic [1:0] {IDLE, LOAD, CMP} estado_t;
endpackage

// File: rtl/carregador_serial_comparador_if.sv
// carregador_serial_comparador_if: serial load inputs and compare result outputs
interface carregador_serial_comparador_if #(parameter int CNT_W = 8);
    import pacote_comparador::*;
    logic             start;
    logic             select;
    logic             bit_a;
    logic             bit_b;
    logic             bit_valid;
    logic             clear_count;
    logic             busy;
    logic [OP_W-1:0]  a_out;
    logic [OP_W-1:0]  b_out;
    logic             select_out;
    logic             s_out;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] match_count;
    modport master (output start, select, bit_a, bit_b, bit_valid, clear_count,
                    input busy, a_out, b_out, select_out, s_out, done, err, match_count);
    modport slave (input start, select, bit_a, bit_b, bit_valid, clear_count,
                   output busy, a_out, b_out, select_out, s_out, done, err, match_count);
endinterface

// File: rtl/carregador_serial_comparador_comparador.sv
// comparador_igualdade: equality (select=0) or difference (select=1) test of two operands
module comparador_igualdade
    import pacote_comparador::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic            select,
    output logic            s
);
    assign s = select ? (a != b) : (a == b);
endmodule

// File: rtl/carregador_serial_comparador.sv
// carregador_serial_comparador: bit-serial operand loader, compare sequencer and match counter
module carregador_serial_comparador
    import pacote_comparador::*;
#(
    parameter int TIMEOUT = 15
) (
    input logic                          clk,
    input logic                          rst_n,
    carregador_serial_comparador_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
    estado_t       state;
    logic [1:0]    bcnt;
    logic [TW-1:0] tcnt;
    logic          s_cmp;

    comparador_igualdade u_cmp (
        .a(bus.a_out),
        .b(bus.b_out),
        .select(bus.select_out),
        .s(s_cmp)
    );

    // sequencer: load three bits, compare once, abort a stalled load, count positive results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bcnt            <= '0;
            tcnt            <= '0;
            bus.busy        <= 1'b0;
            bus.a_out       <= '0;
            bus.b_out       <= '0;
            bus.select_out  <= 1'b0;
            bus.s_out       <= 1'b0;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
            bus.match_count <= '0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state          <= LOAD;
                    bus.busy       <= 1'b1;
                    bus.a_out      <= '0;
                    bus.b_out      <= '0;
                    bus.select_out <= bus.select;
                    bcnt           <= '0;
                    tcnt           <= '0;
                end
                LOAD: if (bus.bit_valid) begin
                    bus.a_out <= {bus.a_out[OP_W-2:0], bus.bit_a};
                    bus.b_out <= {bus.b_out[OP_W-2:0], bus.bit_b};
                    bcnt      <= bcnt + 2'd1;
                    tcnt      <= '0;
                    if (bcnt == 2'(OP_W - 1)) state <= CMP;
                end else if (tcnt == TLIM) begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.err  <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
                CMP: begin
                    state     <= IDLE;
                    bus.busy  <= 1'b0;
                    bus.s_out <= s_cmp;
                    bus.done  <= 1'b1;
                    if (s_cmp && !(&bus.match_count)) bus.match_count <= bus.match_count + 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (bus.clear_count) bus.match_count <= '0;
        end
    end
endmodule

// File: tb/tb_carregador_serial_comparador.sv
// tb_carregador_serial_comparador: randomized scoreboard bench for the serial compare sequencer
module tb_carregador_serial_comparador;
    localparam int TO   = 15;
    localparam int CMAX = 3;

    typedef struct {
        bit         is_err;
        logic [2:0] a;
        logic [2:0] b;
        logic       sel;
        logic       s;
        int         cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt_m = 0;
    logic s_m = 1'b0;

    always #5 clk = ~clk;

    carregador_serial_comparador_if #(.CNT_W(2)) bus ();

    carregador_serial_comparador #(.TIMEOUT(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        bus.start  = 1'($urandom);
        bus.select = 1'($urandom);
        bus.bit_a  = 1'($urandom);
        bus.bit_b  = 1'($urandom);
    endtask

    task automatic zeros(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_a"}, 32'(bus.a_out), 0);
        chk({tag, "_b"}, 32'(bus.b_out), 0);
        chk({tag, "_sel"}, 32'(bus.select_out), 0);
        chk({tag, "_s"}, 32'(bus.s_out), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_err"}, 32'(bus.err), 0);
        chk({tag, "_cnt"}, 32'(bus.match_count), 0);
    endtask

    task automatic push_bits(input logic [2:0] a, input logic [2:0] b, input int nb, input int gap);
        for (int i = 2; i > 2 - nb; i--) begin
            repeat (gap) begin
                noise();
                tick();
            end
            noise();
            bus.bit_valid = 1'b1;
            bus.bit_a = a[i];
            bus.bit_b = b[i];
            tick();
            bus.bit_valid = 1'b0;
        end
    endtask

    task automatic txn(input logic sel, input logic [2:0] a, input logic [2:0] b, input int gap, input bit clr);
        exp_t e;
        logic s;
        s = sel ? (a != b) : (a == b);
        cnt_m = clr ? 0 : ((s && cnt_m < CMAX) ? cnt_m + 1 : cnt_m);
        s_m = s;
        e = '{1'b0, a, b, sel, s, cnt_m};
        q.push_back(e);
        bus.start = 1'b1;
        bus.select = sel;
        tick();
        push_bits(a, b, 3, gap);
        noise();
        bus.clear_count = clr;
        tick();
        bus.clear_count = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic timeout_txn(input logic sel, input logic [2:0] a, input logic [2:0] b, input int nb);
        exp_t e;
        e = '{1'b1, 3'(a >> (3 - nb)), 3'(b >> (3 - nb)), sel, s_m, cnt_m};
        q.push_back(e);
        bus.start = 1'b1;
        bus.select = sel;
        tick();
        push_bits(a, b, nb, 1);
        repeat (TO) begin
            noise();
            tick();
        end
        bus.start = 1'b0;
    endtask

    // scoreboard monitor: every done/err pulse must match the oldest expected outcome
    always @(negedge clk) begin
        if (rst_n && (bus.done || bus.err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none", bus.done, bus.err);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_done", 32'(bus.done), 32'(!e.is_err));
                chk("pulse_err", 32'(bus.err), 32'(e.is_err));
                chk("out_a", 32'(bus.a_out), 32'(e.a));
                chk("out_b", 32'(bus.b_out), 32'(e.b));
                chk("out_sel", 32'(bus.select_out), 32'(e.sel));
                chk("out_s", 32'(bus.s_out), 32'(e.s));
                chk("out_cnt", 32'(bus.match_count), 32'(e.cnt));
                chk("out_busy", 32'(bus.busy), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.start = 0; bus.select = 0; bus.bit_a = 0; bus.bit_b = 0;
        bus.bit_valid = 0; bus.clear_count = 0;
        #12 rst_n = 1'b1;
        repeat (3) tick();
        zeros("reset");
        txn(1'b0, 3'b101, 3'b101, 0, 1'b0);
        txn(1'b1, 3'b010, 3'b101, 2, 1'b0);
        txn(1'b0, 3'b010, 3'b101, 2, 1'b0);
        tick();
        timeout_txn(1'b0, 3'b110, 3'b011, 1);
        tick();
        chk("after_timeout_busy", 32'(bus.busy), 0);
        for (int i = 0; i < 5; i++) begin
            logic [2:0] v;
            v = 3'($urandom);
            txn(1'b0, v, v, 0, 1'b0);
        end
        chk("saturated", 32'(bus.match_count), CMAX);
        txn(1'b0, 3'b111, 3'b111, 0, 1'b1);
        chk("clear_in_cmp", 32'(bus.match_count), 0);
        tick();
        bus.start = 1'b1;
        bus.select = 1'b1;
        tick();
        bus.start = 1'b0;
        push_bits(3'b100, 3'b001, 2, 0);
        #2 rst_n = 1'b0;
        #1 zeros("async_rst");
        cnt_m = 0;
        s_m = 1'b0;
        repeat (2) tick();
        #3 rst_n = 1'b1;
        tick();
        zeros("post_rst");
        txn(1'b1, 3'b011, 3'b010, 1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            int k;
            k = $urandom_range(9, 0);
            if (k == 0) begin
                timeout_txn(1'($urandom), 3'($urandom), 3'($urandom), $urandom_range(2, 0));
            end else if (k == 1) begin
                bus.clear_count = 1'b1;
                tick();
                bus.clear_count = 1'b0;
                cnt_m = 0;
                chk("clear_idle", 32'(bus.match_count), 0);
            end else begin
                logic [2:0] a;
                logic [2:0] b;
                a = 3'($urandom);
                b = ($urandom_range(1, 0) == 1) ? a : 3'($urandom);
                txn(1'($urandom), a, b, $urandom_range(3, 0), $urandom_range(7, 0) == 0);
            end
        end
        repeat (3) tick();
        chk("queue_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/carregador_serial_comparador.md
# carregador_serial_comparador

Serial operand loader and compare sequencer placed directly upstream of `comparador_igualdade`. Two 3-bit operands arrive bit-serially, MSB first, under a start/valid protocol. The block assembles them and drives them, together with the mode bit, into a `comparador_igualdade` instance. It registers the result, flags completion with a one-cycle pulse, aborts stalled loads on timeout, and counts positive results.

## Interface
- `CNT_W`, default 8: width of the saturating positive-result counter.
- `TIMEOUT`, default 15: consecutive LOAD cycles without `bit_valid` that cause an abort. Must be ≥ 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a load; sampled only in IDLE.
- `select` in 1: mode, sampled together with an accepted `start`. 0 = equality, 1 = difference.
- `bit_a` in 1: serial bit of operand a.
- `bit_b` in 1: serial bit of operand b.
- `bit_valid` in 1: qualifies `bit_a`/`bit_b`; sampled only in LOAD.
- `clear_count` in 1: synchronous clear of `match_count`.
- `busy` out 1: high whenever state ≠ IDLE.
- `a_out` out 3: operand a shift register, fed to the comparator.
- `b_out` out 3: operand b shift register, fed to the comparator.
- `select_out` out 1: captured mode, fed to the comparator.
- `s_out` out 1: registered comparator result of the last completed compare.
- `done` out 1: one-cycle pulse when `s_out` is updated.
- `err` out 1: one-cycle pulse on timeout abort.
- `match_count` out CNT_W: count of compares that returned `s_out` = 1.

## Operation
- **States:** IDLE, LOAD, CMP.
- **IDLE → LOAD** on `start` = 1.
  - Same edge: `a_out` and `b_out` clear to 0.
  - Same edge: `select_out` ← `select`.
  - Same edge: the bit counter and timeout counter clear.
- **LOAD, `bit_valid` = 1:**
  - `a_out` ← {`a_out`[1:0], `bit_a`} and `b_out` ← {`b_out`[1:0], `bit_b`}.
  - Bit counter increments; timeout counter clears.
- **LOAD, third accepted bit:** state goes to CMP on that edge.
- **LOAD, `bit_valid` = 0:** timeout counter increments.
  - When it would reach `TIMEOUT`, state goes to IDLE and `err` = 1 for one cycle.
  - `s_out` and `match_count` do not change on an abort.
- **CMP:** lasts exactly one cycle.
  - `s_out` ← comparator output.
  - `done` = 1 for one cycle.
  - If the result is 1, `match_count` increments, saturating at 2^CNT_W − 1.
  - State goes to IDLE.
- **Ignored inputs:**
  - `start` while busy.
  - `bit_valid` outside LOAD.
  - `select` except at an accepted `start`.
- **`clear_count`:** takes effect in any state and has priority over a same-cycle increment; the count goes to 0.
- **Hold behaviour:** `a_out`, `b_out` and `select_out` hold their values in IDLE. `s_out` holds until the next CMP.
- **Reset values:**
  - State IDLE.
  - `a_out`, `b_out`, `select_out`, `s_out`, `done`, `err`, `match_count` and `busy` all 0.
  - Internal counters 0.
- **Reset mid-operation:** immediate return to the reset values. No `done` or `err` is produced for the aborted load.

## Timing
- Third bit sampled at edge k:
  - `a_out`/`b_out` hold the final operands after edge k.
  - `s_out` and `done` are valid after edge k+1.
  - `done` falls at edge k+2.
- Minimum start-to-done time is 5 edges: start, three bits, CMP.
- `busy` falls at edge k+1, in the same cycle that `done` is high. A `start` in that cycle is accepted.
- Timeout abort occurs at the `TIMEOUT`-th consecutive edge in LOAD with `bit_valid` = 0.

## Structure
- Package `pacote_comparador` holds:
  - the state enum (IDLE, LOAD, CMP);
  - localparam `OP_W` = 3, the operand width fixed by the comparator.
- Sub-module: one instance of `comparador_igualdade`.
  - Inputs: `a_out`, `b_out`, `select_out`.
  - Its output is sampled in CMP.

## Test plan
- **Reset:** assert reset, release, no stimulus → all outputs 0, `busy` = 0.
- **Equality match:** `start` with `select` = 0, bits a = 101 and b = 101 on consecutive cycles → `a_out` = `b_out` = 101, `s_out` = 1, `done` one cycle, `match_count` = 1.
- **Difference mode:** `select` = 1, a = 010, b = 101, `bit_valid` gapped by 2 idle cycles → `s_out` = 1, `match_count` increments. Then `select` = 0 with the same operands → `s_out` = 0 and the count is unchanged.
- **Timeout:** `TIMEOUT` = 15; `start`, one bit, then 15 cycles without `bit_valid` → `err` pulses once, state IDLE, `s_out` and count unchanged. `start` during LOAD is ignored.
- **Counter saturation and clear:** `CNT_W` = 2, run 5 matching compares → `match_count` saturates at 3. `clear_count` in a CMP cycle → count = 0.
- **Async reset mid-LOAD:** `rst_n` low after 2 bits → immediate zeros, no `done`. After release a fresh sequence completes normally.
